// File: rtl/bitmask_sequencer_if.sv
// bitmask_sequencer_if
//   Handshake/bus bundle for bitmask_sequencer.
//   master: requester/consumer side (drives start, mask, abort, out_ready, base).
//   slave : sequencer side (drives busy, out_valid, idx, last, count, done, addr).
//   Optional macro BMSEQ_ADDR_EN adds base (in) / addr (out).
interface bitmask_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);
  logic             start;
  logic [WIDTH-1:0] mask;
  logic             abort;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic [IDX_W:0]   count;
  logic             done;
`ifdef BMSEQ_ADDR_EN
  logic [31:0]      base;
  logic [31:0]      addr;

  modport master (output start, mask, abort, out_ready, base,
                  input  busy, out_valid, idx, last, count, done, addr);
  modport slave  (input  start, mask, abort, out_ready, base,
                  output busy, out_valid, idx, last, count, done, addr);
`else
  modport master (output start, mask, abort, out_ready,
                  input  busy, out_valid, idx, last, count, done);
  modport slave  (input  start, mask, abort, out_ready,
                  output busy, out_valid, idx, last, count, done);
`endif
endinterface

// File: rtl/bitmask_sequencer.sv
// bitmask_sequencer
//   Walks a register-list mask and emits the index of each set bit, lowest
//   first, one per accepted valid/ready handshake; pulses done when the mask
//   is exhausted. Used to sequence load/store-multiple transfers.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   bus   - bitmask_sequencer_if.slave: start/mask/abort in, busy/out_valid/
//           idx/last/count/done out, out_ready in.
// Optional macro BMSEQ_ADDR_EN: captures bus.base on start and drives
//   bus.addr = base + 4*count, wrapping modulo 2^32.
module bitmask_sequencer #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  bitmask_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W:0]   count_q, count_d;
`ifdef BMSEQ_ADDR_EN
  logic [31:0]      addr_q, addr_d;
`endif

  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_found;
  logic [WIDTH-1:0] pending_clr;
  logic             hs;

  // Lowest-set-bit finder; its all-ones "no bit" code is masked off idx below.
  always_comb begin
    lsb_idx   = '1;
    lsb_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!lsb_found && pending_q[i]) begin
        lsb_idx   = IDX_W'(i);
        lsb_found = 1'b1;
      end
    end
  end

  // x & (x-1) clears the lowest set bit; zero result means it was the last one.
  assign pending_clr = pending_q & (pending_q - WIDTH'(1));
  assign hs          = (state_q == S_RUN) && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
`ifdef BMSEQ_ADDR_EN
    addr_d    = addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          count_d = '0;
`ifdef BMSEQ_ADDR_EN
          addr_d  = bus.base;
`endif
          if (bus.mask != '0) begin
            pending_d = bus.mask;
            state_d   = S_RUN;
          end else begin
            state_d   = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          pending_d = pending_clr;
          count_d   = count_q + 1'b1;
`ifdef BMSEQ_ADDR_EN
          addr_d    = addr_q + 32'd4;
`endif
        end
        // Abort wins over completion, but a coincident transfer still counts.
        if (bus.abort) begin
          pending_d = '0;
          state_d   = S_IDLE;
        end else if (hs && pending_clr == '0) begin
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      count_q   <= '0;
`ifdef BMSEQ_ADDR_EN
      addr_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
`ifdef BMSEQ_ADDR_EN
      addr_q    <= addr_d;
`endif
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_RUN);
  assign bus.idx       = (state_q == S_RUN) ? lsb_idx : '0;
  assign bus.last      = (state_q == S_RUN) && (pending_q != '0) && (pending_clr == '0);
  assign bus.count     = count_q;
  assign bus.done      = (state_q == S_DONE);
`ifdef BMSEQ_ADDR_EN
  assign bus.addr      = addr_q;
`endif

endmodule
